burst_frame_rx: RTL
===================

# burst_frame_rx

Receiver and decoder for the walkie-talkie burst/silence line protocol. It takes the already-synchronized receive pin and measures high ("burst") and low ("silence") durations against the shared timing parameters. It recovers one WIDTH-bit ciphertext block per frame and hands it to the decipher stage with a single-cycle strobe. It sits between the input synchronizer and the decipher block, in the 98.3 MHz audio clock domain.

## Interface
Parameters:
- SBD, 500, sync burst duration (cycles)
- SSD, 500, sync silence duration
- BBD, 300, bit burst and stop burst duration
- BSD0, 150, bit silence duration for a 0
- BSD1, 300, bit silence duration for a 1
- MARGIN, 50, allowed ± deviation on every duration
- WIDTH, 128, bits per frame
- CW, 16, duration counter width; must hold max(SBD,SSD,BBD,BSD1)+MARGIN+1

Ports:
- clk_in  input  1  system clock (98.3 MHz)
- rst_in  input  1  reset; one clock; reset is asynchronous and active-low
- signal_in  input  1  synchronized line; idle level 0
- code_out  output  WIDTH  last successfully received block
- new_code_out  output  1  single-cycle strobe; code_out is new
- error_out  output  3  last error code (0 = none)
- state_out  output  4  current FSM state encoding

## Operation
- Frame on the line, in order:
  - high SBD cycles
  - low SSD cycles
  - WIDTH bits, MSB first; each bit is high BBD cycles, then low BSD0 (0) or BSD1 (1) cycles
  - stop burst: high BBD cycles
  - return to idle low
- Duration = number of consecutive clk_in samples at one level, counted from the edge.
- A duration is judged when the level changes: it is valid if inside the inclusive window [D-MARGIN, D+MARGIN].
- Timeout: if a level persists past D+MARGIN (largest D for bit silence), the error is raised immediately without waiting for the edge.
- FSM states (state_out): IDLE=0, SYNC_HI=1, SYNC_LO=2, BIT_HI=3, BIT_LO=4, STOP_HI=5.
- IDLE: rising edge → SYNC_HI.
- SYNC_HI: falling edge in SBD window → SYNC_LO; otherwise error 1 → IDLE.
- SYNC_LO: rising edge in SSD window → BIT_HI, bit counter cleared; otherwise error 2 → IDLE.
- BIT_HI: falling edge in BBD window → BIT_LO; otherwise error 3 → IDLE.
- BIT_LO: on rising edge:
  - silence in BSD0 window shifts in 0; silence in BSD1 window shifts in 1
  - any other length → error 4 → IDLE; silence exceeding BSD1+MARGIN also gives error 4
  - after WIDTH bits → STOP_HI, else → BIT_HI
- STOP_HI: falling edge in BBD window → code_out loaded from shift register, new_code_out pulsed, error_out cleared to 0 → IDLE; otherwise error 5 → IDLE.
- Error → IDLE always discards the partial shift register and never pulses new_code_out.
- IDLE entered while the line is high waits for the next rising edge; no false sync from a held-high line.
- error_out is sticky: it holds until the next successful frame (cleared) or a new error (overwritten).
- code_out changes only on a successful frame.

## Timing
- Reset (rst_in=0, asynchronous): state IDLE, code_out=0, new_code_out=0, error_out=0, counters and shift register cleared.
- Reset asserted mid-frame aborts the frame with no strobe. After release, decoding restarts at the next rising edge.
- Edges are detected against a one-cycle registered copy of signal_in.
- new_code_out is high for exactly one cycle, the cycle after the clock edge that first samples signal_in=0 following the stop burst. code_out is valid in that same cycle.
- error_out and state_out update on the same clock edge as the FSM transition.
- Back-to-back frames are accepted: the next sync burst may begin any cycle after the stop burst ends.

## Test plan
- Clean frame carrying 128'h0123456789ABCDEF_FEDCBA9876543210 with nominal durations → one new_code_out pulse, code_out equal to the sent block, error_out=0, state_out back to 0.
- Window edges: bursts of 250 and 350, bit silences of 100/200 (0) and 250/350 (1) → frame accepted. Repeat with a bit silence of 99 → error_out=4, no strobe.
- Sync burst of 449 cycles → error_out=1 and IDLE at the falling edge. A following clean frame decodes and clears error_out to 0.
- Bit silence of 225 cycles (between windows) → error_out=4. Line then held low after bit 10 → error_out=4 raised exactly at cycle BSD1+MARGIN+1 of the silence.
- Stop burst of 200 cycles → error_out=5, code_out keeps its previous value.
- rst_in pulsed low during bit 60 → all outputs 0 immediately. A subsequent clean frame decodes correctly.

Source files
------------

// File: rtl/burst_frame_rx.sv
// Burst/silence line decoder: times each level of the synchronized receive pin
// and assembles one WIDTH-bit block per valid frame, strobing it out once.
module burst_frame_rx #(
    parameter int SBD    = 500,
    parameter int SSD    = 500,
    parameter int BBD    = 300,
    parameter int BSD0   = 150,
    parameter int BSD1   = 300,
    parameter int MARGIN = 50,
    parameter int WIDTH  = 128,
    parameter int CW     = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             signal_in,
    output logic [WIDTH-1:0] code_out,
    output logic             new_code_out,
    output logic [2:0]       error_out,
    output logic [3:0]       state_out
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SYNC_HI = 4'd1,
        S_SYNC_LO = 4'd2,
        S_BIT_HI  = 4'd3,
        S_BIT_LO  = 4'd4,
        S_STOP_HI = 4'd5
    } state_t;

    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] SBD_MIN  = CW'(SBD - MARGIN);
    localparam logic [CW-1:0] SBD_MAX  = CW'(SBD + MARGIN);
    localparam logic [CW-1:0] SSD_MIN  = CW'(SSD - MARGIN);
    localparam logic [CW-1:0] SSD_MAX  = CW'(SSD + MARGIN);
    localparam logic [CW-1:0] BBD_MIN  = CW'(BBD - MARGIN);
    localparam logic [CW-1:0] BBD_MAX  = CW'(BBD + MARGIN);
    localparam logic [CW-1:0] BSD0_MIN = CW'(BSD0 - MARGIN);
    localparam logic [CW-1:0] BSD0_MAX = CW'(BSD0 + MARGIN);
    localparam logic [CW-1:0] BSD1_MIN = CW'(BSD1 - MARGIN);
    localparam logic [CW-1:0] BSD1_MAX = CW'(BSD1 + MARGIN);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_sig_d;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bits;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_code;
    logic             r_new;
    logic [2:0]       r_err;

    logic             w_edge;
    logic             w_err;
    logic [2:0]       w_code;
    logic [CW-1:0]    w_lim;
    logic             w_shift;
    logic             w_bit;
    logic             w_clr;
    logic             w_done;

    function automatic logic in_win(input logic [CW-1:0] c,
                                    input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    assign w_edge = signal_in ^ r_sig_d;

    // r_cnt holds the length of the level that just ended on the edge cycle
    always_comb begin
        w_nxt   = r_state;
        w_err   = 1'b0;
        w_code  = 3'd0;
        w_lim   = '1;
        w_shift = 1'b0;
        w_bit   = 1'b0;
        w_clr   = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge && signal_in) w_nxt = S_SYNC_HI;
            end
            S_SYNC_HI: begin
                w_code = 3'd1;
                w_lim  = SBD_MAX;
                if (w_edge) begin
                    if (in_win(r_cnt, SBD_MIN, SBD_MAX)) w_nxt = S_SYNC_LO;
                    else                                 w_err = 1'b1;
                end
            end
            S_SYNC_LO: begin
                w_code = 3'd2;
                w_lim  = SSD_MAX;
                if (w_edge) begin
                    if (in_win(r_cnt, SSD_MIN, SSD_MAX)) begin
                        w_nxt = S_BIT_HI;
                        w_clr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_BIT_HI: begin
                w_code = 3'd3;
                w_lim  = BBD_MAX;
                if (w_edge) begin
                    if (in_win(r_cnt, BBD_MIN, BBD_MAX)) w_nxt = S_BIT_LO;
                    else                                 w_err = 1'b1;
                end
            end
            S_BIT_LO: begin
                w_code = 3'd4;
                w_lim  = BSD1_MAX;
                if (w_edge) begin
                    if (in_win(r_cnt, BSD0_MIN, BSD0_MAX) || in_win(r_cnt, BSD1_MIN, BSD1_MAX)) begin
                        w_shift = 1'b1;
                        w_bit   = in_win(r_cnt, BSD1_MIN, BSD1_MAX);
                        w_nxt   = (r_bits == LAST_BIT) ? S_STOP_HI : S_BIT_HI;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_STOP_HI: begin
                w_code = 3'd5;
                w_lim  = BBD_MAX;
                if (w_edge) begin
                    if (in_win(r_cnt, BBD_MIN, BBD_MAX)) begin
                        w_done = 1'b1;
                        w_nxt  = S_IDLE;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        // A level that has already outlived its window fails without waiting for the edge
        if (r_state != S_IDLE && !w_edge && r_cnt >= w_lim) w_err = 1'b1;
        if (w_err) w_nxt = S_IDLE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_sig_d <= 1'b0;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_code  <= '0;
            r_new   <= 1'b0;
            r_err   <= 3'd0;
        end else begin
            r_state <= w_nxt;
            r_sig_d <= signal_in;
            if (w_edge)            r_cnt <= CW'(1);
            else if (r_cnt != '1)  r_cnt <= r_cnt + CW'(1);
            if (w_clr || w_err) begin
                r_shift <= '0;
                r_bits  <= '0;
            end else if (w_shift) begin
                r_shift <= {r_shift[WIDTH-2:0], w_bit};
                r_bits  <= r_bits + BW'(1);
            end
            r_new <= w_done;
            if (w_done) begin
                r_code <= r_shift;
                r_err  <= 3'd0;
            end else if (w_err) begin
                r_err  <= w_code;
            end
        end
    end

    assign code_out     = r_code;
    assign new_code_out = r_new;
    assign error_out    = r_err;
    assign state_out    = r_state;

endmodule
